// File: rtl/dot_product_tile_accumulator.sv
// Sums NUM_TILES consecutive dot-product tiles, then rounds, shifts and saturates the sum.
// Finished results are queued in a 2-entry FIFO with a valid/ack handshake.
module dot_product_tile_accumulator #(
  parameter int IN_WIDTH  = 24,
  parameter int NUM_TILES = 4,
  parameter int SHIFT     = 2,
  parameter int OUT_WIDTH = 16,
  localparam int ACC_WIDTH = IN_WIDTH + $clog2(NUM_TILES) + ((NUM_TILES == 1) ? 1 : 0),
  localparam int TW        = $clog2(NUM_TILES) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       inReady,
  input  logic signed [IN_WIDTH-1:0] DP,
  input  logic                       clear,
  input  logic                       outAck,
  output logic                       outReady,
  output logic [OUT_WIDTH-1:0]       Result,
  output logic                       ResultSat,
  output logic                       dropErr,
  output logic [TW-1:0]              tileIdx
);

  localparam int RW = ACC_WIDTH + 1;
  localparam int CW = ((RW > OUT_WIDTH) ? RW : OUT_WIDTH) + 1;
  localparam logic signed [RW-1:0] RND  = RW'((2 ** SHIFT) / 2);
  localparam logic [TW-1:0]        LAST = TW'(NUM_TILES - 1);
  localparam logic signed [CW-1:0] MAXV = $signed({{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [CW-1:0] MINV = $signed({{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  // Returns {sat, result}: half-up rounding, arithmetic shift, clamp to OUT_WIDTH.
  function automatic logic [OUT_WIDTH:0] round_sat(input logic signed [ACC_WIDTH-1:0] sum);
    logic signed [RW-1:0] rnd;
    logic signed [CW-1:0] ext;
    logic [OUT_WIDTH:0]   res;
    rnd = (RW'(sum) + RND) >>> SHIFT;
    ext = CW'(rnd);
    if (ext > MAXV) begin
      res = {1'b1, MAXV[OUT_WIDTH-1:0]};
    end else if (ext < MINV) begin
      res = {1'b1, MINV[OUT_WIDTH-1:0]};
    end else begin
      res = {1'b0, ext[OUT_WIDTH-1:0]};
    end
    return res;
  endfunction

  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH-1:0] s1_sum_r;
  logic                        s1_valid_r;
  logic [TW-1:0]               tile_r;
  logic [OUT_WIDTH:0]          head_r;
  logic [OUT_WIDTH:0]          tail_r;
  logic [1:0]                  cnt_r;
  logic                        ready_r;
  logic                        drop_r;

  logic signed [ACC_WIDTH-1:0] sum_s;
  logic [OUT_WIDTH:0]          push_val_s;
  logic                        push_s;
  logic                        pop_s;
  logic [1:0]                  cnt_nxt_s;

  // Next-state helpers: tile sum, stage-2 result, FIFO push/pop and occupancy.
  always_comb begin
    sum_s      = acc_r + ACC_WIDTH'(DP);
    push_val_s = round_sat(s1_sum_r);
    push_s     = enable && s1_valid_r && !clear;
    pop_s      = enable && (cnt_r != 2'd0) && outAck;
    cnt_nxt_s  = cnt_r;
    case (cnt_r)
      2'd0: begin
        if (push_s) cnt_nxt_s = 2'd1;
        else        cnt_nxt_s = 2'd0;
      end
      2'd1: begin
        if (push_s && !pop_s)      cnt_nxt_s = 2'd2;
        else if (!push_s && pop_s) cnt_nxt_s = 2'd0;
        else                       cnt_nxt_s = 2'd1;
      end
      2'd2: begin
        if (pop_s && !push_s) cnt_nxt_s = 2'd1;
        else                  cnt_nxt_s = 2'd2;
      end
      default: cnt_nxt_s = 2'd0;
    endcase
  end

  // Tile accumulation and stage-1 capture of a completed group.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r      <= '0;
      tile_r     <= '0;
      s1_sum_r   <= '0;
      s1_valid_r <= 1'b0;
    end else if (enable) begin
      if (clear) begin
        acc_r      <= '0;
        tile_r     <= '0;
        s1_valid_r <= 1'b0;
      end else if (inReady && (tile_r == LAST)) begin
        s1_sum_r   <= sum_s;
        s1_valid_r <= 1'b1;
        acc_r      <= '0;
        tile_r     <= '0;
      end else if (inReady) begin
        acc_r      <= sum_s;
        tile_r     <= tile_r + TW'(1);
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= 1'b0;
      end
    end
  end

  // Output FIFO; head_r drives Result so it only moves on a pop or a push into an empty FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      cnt_r   <= 2'd0;
      ready_r <= 1'b0;
      drop_r  <= 1'b0;
    end else if (enable) begin
      cnt_r   <= cnt_nxt_s;
      ready_r <= (cnt_nxt_s != 2'd0);
      case (cnt_r)
        2'd0: begin
          if (push_s) head_r <= push_val_s;
        end
        2'd1: begin
          if (push_s && pop_s) head_r <= push_val_s;
          else if (push_s)     tail_r <= push_val_s;
        end
        2'd2: begin
          if (pop_s) begin
            head_r <= tail_r;
            if (push_s) tail_r <= push_val_s;
          end else if (push_s) begin
            drop_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign outReady  = ready_r;
  assign Result    = head_r[OUT_WIDTH-1:0];
  assign ResultSat = head_r[OUT_WIDTH];
  assign dropErr   = drop_r;
  assign tileIdx   = tile_r;

endmodule
